bmem_line_arbiter: RTL and testbench

- Sits between the CPU's instruction cache, data cache and the banked burst memory port (bmem_*) driven by the DRAM controller model in the top-level bench.
- Arbitrates the two 256-bit cache-line clients onto the single 64-bit burst interface.
- Serialises each write line into 4 beats.
- Reassembles 4-beat read responses into full lines, matching responses to requesters by returned address (bmem_raddr), because the controller may return reads out of request order.

---
 rtl/bmem_line_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_bmem_line_arbiter.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bmem_line_arbiter.sv
// Arbitrates I-cache and D-cache 256-bit line traffic onto a 64-bit burst memory port.
// Writes are serialised into 4 beats; read beats are steered back by returned line address.
module bmem_line_arbiter #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned LINE_W = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              i_read,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,
    output logic [ADDR_W-1:0] bmem_addr,
    output logic              bmem_read,
    output logic              bmem_write,
    output logic [63:0]       bmem_wdata,
    input  logic              bmem_ready,
    input  logic [ADDR_W-1:0] bmem_raddr,
    input  logic [63:0]       bmem_rdata,
    input  logic              bmem_rvalid,
    output logic              err
);

    typedef enum logic {IDLE, WBEAT} state_t;

    state_t            state;
    logic [1:0]        wbeat;
    logic [ADDR_W-6:0] w_line;
    logic [ADDR_W-6:0] i_line;
    logic [ADDR_W-6:0] d_line;
    logic              i_out;
    logic              d_out;
    logic [1:0]        i_cnt;
    logic [1:0]        d_cnt;
    logic              rr_d;

    logic [ADDR_W-6:0] i_req_line;
    logic [ADDR_W-6:0] d_req_line;
    logic [ADDR_W-6:0] r_line;
    logic              i_elig;
    logic              d_elig;
    logic              grant_i;
    logic              grant_d;
    logic              hit_i;
    logic              hit_d;
    logic              miss;
    logic              unused_low_bits;

    assign i_req_line      = i_addr[ADDR_W-1:5];
    assign d_req_line      = d_addr[ADDR_W-1:5];
    assign r_line          = bmem_raddr[ADDR_W-1:5];
    assign unused_low_bits = ^{i_addr[4:0], d_addr[4:0], bmem_raddr[4:0]};

    // A client is blocked while outstanding, during its resp cycle, and by a same-line read of the other client.
    always_comb begin
        i_elig  = 1'b0;
        d_elig  = 1'b0;
        grant_i = 1'b0;
        grant_d = 1'b0;
        if (rst && state == IDLE && bmem_ready) begin
            i_elig = i_read && !i_out && !i_resp && !(d_out && d_line == i_req_line);
            d_elig = (d_read || d_write) && !d_out && !d_resp &&
                     !(d_read && !d_write && i_out && i_line == d_req_line);
        end
        grant_d = d_elig && (rr_d || !i_elig);
        grant_i = i_elig && !grant_d;
    end

    // Issue is combinational so a request goes out in the same cycle bmem_ready is seen.
    always_comb begin
        bmem_addr  = '0;
        bmem_read  = 1'b0;
        bmem_write = 1'b0;
        bmem_wdata = '0;
        if (rst && state == WBEAT) begin
            bmem_write = 1'b1;
            bmem_addr  = {w_line, 5'b0};
            bmem_wdata = d_wdata[{wbeat, 6'b0} +: 64];
        end else if (grant_d) begin
            bmem_addr = {d_req_line, 5'b0};
            if (d_write) begin
                bmem_write = 1'b1;
                bmem_wdata = d_wdata[63:0];
            end else begin
                bmem_read = 1'b1;
            end
        end else if (grant_i) begin
            bmem_addr = {i_req_line, 5'b0};
            bmem_read = 1'b1;
        end
    end

    always_comb begin
        hit_i = bmem_rvalid && i_out && i_line == r_line;
        hit_d = bmem_rvalid && d_out && d_line == r_line && !hit_i;
        miss  = bmem_rvalid && !hit_i && !hit_d;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            wbeat   <= '0;
            w_line  <= '0;
            i_line  <= '0;
            d_line  <= '0;
            i_out   <= 1'b0;
            d_out   <= 1'b0;
            i_cnt   <= '0;
            d_cnt   <= '0;
            rr_d    <= 1'b1;
            i_rdata <= '0;
            d_rdata <= '0;
            i_resp  <= 1'b0;
            d_resp  <= 1'b0;
            err     <= 1'b0;
        end else begin
            i_resp <= 1'b0;
            d_resp <= 1'b0;

            case (state)
                IDLE: begin
                    if (grant_d && d_write) begin
                        state  <= WBEAT;
                        wbeat  <= 2'd1;
                        w_line <= d_req_line;
                    end
                end
                WBEAT: begin
                    wbeat <= wbeat + 2'd1;
                    if (wbeat == 2'd3) begin
                        state  <= IDLE;
                        d_resp <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase

            if (grant_i || grant_d) begin
                rr_d <= !rr_d;
            end
            if (grant_i) begin
                i_out  <= 1'b1;
                i_line <= i_req_line;
                i_cnt  <= '0;
            end
            if (grant_d && !d_write) begin
                d_out  <= 1'b1;
                d_line <= d_req_line;
                d_cnt  <= '0;
            end

            if (hit_i) begin
                i_rdata[{i_cnt, 6'b0} +: 64] <= bmem_rdata;
                i_cnt <= i_cnt + 2'd1;
                if (i_cnt == 2'd3) begin
                    i_out  <= 1'b0;
                    i_resp <= 1'b1;
                end
            end
            if (hit_d) begin
                d_rdata[{d_cnt, 6'b0} +: 64] <= bmem_rdata;
                d_cnt <= d_cnt + 2'd1;
                if (d_cnt == 2'd3) begin
                    d_out  <= 1'b0;
                    d_resp <= 1'b1;
                end
            end

            if (miss || (d_read && d_write) || (i_out && !i_read) ||
                (d_out && !d_read) || (state == WBEAT && !d_write)) begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_bmem_line_arbiter.sv
// Directed bench for bmem_line_arbiter: expected bus requests and client responses are queued
// by the stimulus and consumed by a negedge monitor.
module tb_bmem_line_arbiter;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned LINE_W = 256;

    logic              clk = 1'b0;
    logic              rst;
    logic [ADDR_W-1:0] i_addr;
    logic              i_read;
    logic [LINE_W-1:0] i_rdata;
    logic              i_resp;
    logic [ADDR_W-1:0] d_addr;
    logic              d_read;
    logic              d_write;
    logic [LINE_W-1:0] d_wdata;
    logic [LINE_W-1:0] d_rdata;
    logic              d_resp;
    logic [ADDR_W-1:0] bmem_addr;
    logic              bmem_read;
    logic              bmem_write;
    logic [63:0]       bmem_wdata;
    logic              bmem_ready;
    logic [ADDR_W-1:0] bmem_raddr;
    logic [63:0]       bmem_rdata;
    logic              bmem_rvalid;
    logic              err;

    bmem_line_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
        .clk(clk), .rst(rst),
        .i_addr(i_addr), .i_read(i_read), .i_rdata(i_rdata), .i_resp(i_resp),
        .d_addr(d_addr), .d_read(d_read), .d_write(d_write), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_resp(d_resp),
        .bmem_addr(bmem_addr), .bmem_read(bmem_read), .bmem_write(bmem_write),
        .bmem_wdata(bmem_wdata), .bmem_ready(bmem_ready), .bmem_raddr(bmem_raddr),
        .bmem_rdata(bmem_rdata), .bmem_rvalid(bmem_rvalid), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_write;
        logic [31:0] addr;
        logic [63:0] data;
    } bus_t;

    typedef struct {
        bit           is_d;
        bit           chk_data;
        logic [255:0] data;
    } resp_t;

    bus_t  bus_q[$];
    resp_t resp_q[$];
    int    checks = 0;
    int    errors = 0;

    task automatic check(input string name, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_bus(input bit w, input logic [31:0] a, input logic [63:0] d);
        bus_t b;
        b.is_write = w;
        b.addr     = a;
        b.data     = d;
        bus_q.push_back(b);
    endtask

    task automatic exp_resp(input bit is_d, input bit chk, input logic [255:0] d);
        resp_t r;
        r.is_d     = is_d;
        r.chk_data = chk;
        r.data     = d;
        resp_q.push_back(r);
    endtask

    function automatic logic [255:0] line_of(input logic [63:0] base);
        return {base * 64'd4, base * 64'd3, base * 64'd2, base};
    endfunction

    task automatic send_beats(input logic [31:0] a, input logic [63:0] base);
        for (int k = 0; k < 4; k++) begin
            bmem_rvalid = 1'b1;
            bmem_raddr  = a;
            bmem_rdata  = base * 64'(k + 1);
            tick();
        end
        bmem_rvalid = 1'b0;
        bmem_raddr  = '0;
        bmem_rdata  = '0;
    endtask

    task automatic pop_resp(input bit from_d, input logic [255:0] data);
        resp_t r;
        if (resp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL resp_unexpected actual=%s required=none", from_d ? "d_resp" : "i_resp");
        end else begin
            r = resp_q.pop_front();
            check("resp_owner", {255'b0, from_d}, {255'b0, r.is_d});
            if (r.chk_data) check(from_d ? "d_rdata" : "i_rdata", data, r.data);
        end
    endtask

    initial begin
        bus_t b;
        forever begin
            @(negedge clk);
            if (bmem_read || bmem_write) begin
                if (bus_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL bus_unexpected actual=rd%0b/wr%0b@%h required=none",
                             bmem_read, bmem_write, bmem_addr);
                end else begin
                    b = bus_q.pop_front();
                    check("bus_kind", {254'b0, bmem_read, bmem_write}, b.is_write ? 256'd1 : 256'd2);
                    check("bus_addr", {224'b0, bmem_addr}, {224'b0, b.addr});
                    if (b.is_write) check("bus_wdata", {192'b0, bmem_wdata}, {192'b0, b.data});
                end
            end
            if (i_resp) pop_resp(1'b0, i_rdata);
            if (d_resp) pop_resp(1'b1, d_rdata);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b0; i_addr = '0; i_read = 1'b0; d_addr = '0; d_read = 1'b0; d_write = 1'b0;
        d_wdata = '0; bmem_ready = 1'b1; bmem_raddr = '0; bmem_rdata = '0; bmem_rvalid = 1'b0;
        repeat (3) tick();
        check("reset_bus", {155'b0, bmem_addr, bmem_read, bmem_write, bmem_wdata, i_resp, d_resp, err}, '0);
        check("reset_i_rdata", i_rdata, '0);
        check("reset_d_rdata", d_rdata, '0);
        rst = 1'b1;
        tick();

        // I-cache read, unaligned address
        exp_bus(1'b0, 32'h0000_1040, '0);
        exp_resp(1'b0, 1'b1, {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                              64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111});
        i_addr = 32'h0000_1044; i_read = 1'b1;
        tick();
        send_beats(32'h0000_1040, 64'h1111_1111_1111_1111);
        check("i_resp_latency", {255'b0, i_resp}, 256'd1);
        tick();
        i_read = 1'b0;
        tick();

        // D-cache write of four distinct words
        d_wdata = {64'hD3D3_0000_0000_0003, 64'hD2D2_0000_0000_0002,
                   64'hD1D1_0000_0000_0001, 64'hD0D0_0000_0000_0000};
        exp_bus(1'b1, 32'h0000_2000, 64'hD0D0_0000_0000_0000);
        exp_bus(1'b1, 32'h0000_2000, 64'hD1D1_0000_0000_0001);
        exp_bus(1'b1, 32'h0000_2000, 64'hD2D2_0000_0000_0002);
        exp_bus(1'b1, 32'h0000_2000, 64'hD3D3_0000_0000_0003);
        exp_resp(1'b1, 1'b0, '0);
        d_addr = 32'h0000_2000; d_write = 1'b1;
        repeat (4) tick();
        check("d_write_resp_latency", {255'b0, d_resp}, 256'd1);
        tick();
        d_write = 1'b0;
        tick();

        // simultaneous reads, D favoured, memory answers D first
        exp_bus(1'b0, 32'h0000_0200, '0);
        exp_bus(1'b0, 32'h0000_0100, '0);
        exp_resp(1'b1, 1'b1, line_of(64'h0D0D_0000_0000_0001));
        exp_resp(1'b0, 1'b1, line_of(64'h0101_0000_0000_0001));
        i_addr = 32'h0000_0100; i_read = 1'b1;
        d_addr = 32'h0000_0200; d_read = 1'b1;
        repeat (2) tick();
        send_beats(32'h0000_0200, 64'h0D0D_0000_0000_0001);
        check("d_resp_first", {254'b0, d_resp, i_resp}, 256'd2);
        tick();
        d_read = 1'b0;
        send_beats(32'h0000_0100, 64'h0101_0000_0000_0001);
        check("i_resp_second", {254'b0, d_resp, i_resp}, 256'd1);
        tick();
        i_read = 1'b0;
        tick();

        // both clients read the same line: second issue waits for first completion
        exp_bus(1'b0, 32'h0000_0300, '0);
        exp_resp(1'b1, 1'b1, line_of(64'h0303_0303_0303_0303));
        exp_resp(1'b0, 1'b1, line_of(64'h0303_0303_0303_0303));
        i_addr = 32'h0000_0300; i_read = 1'b1;
        d_addr = 32'h0000_0300; d_read = 1'b1;
        tick();
        #1;
        check("hazard_hold", {255'b0, bmem_read}, '0);
        send_beats(32'h0000_0300, 64'h0303_0303_0303_0303);
        exp_bus(1'b0, 32'h0000_0300, '0);
        tick();
        d_read = 1'b0;
        send_beats(32'h0000_0300, 64'h0303_0303_0303_0303);
        tick();
        i_read = 1'b0;
        tick();

        // memory not ready for five cycles
        bmem_ready = 1'b0;
        i_addr = 32'h0000_0400; i_read = 1'b1;
        for (int c = 0; c < 5; c++) begin
            #1;
            check("ready_hold", {255'b0, bmem_read}, '0);
            tick();
        end
        exp_bus(1'b0, 32'h0000_0400, '0);
        exp_resp(1'b0, 1'b1, line_of(64'h0404_0000_0404_0000));
        bmem_ready = 1'b1;
        #1;
        check("ready_issue", {255'b0, bmem_read}, 256'd1);
        tick();
        send_beats(32'h0000_0400, 64'h0404_0000_0404_0000);
        tick();
        i_read = 1'b0;
        tick();
        check("err_clean", {255'b0, err}, '0);

        // stray read beat sets sticky err
        bmem_rvalid = 1'b1; bmem_raddr = 32'hDEAD_0000; bmem_rdata = 64'hBAD;
        tick();
        bmem_rvalid = 1'b0; bmem_raddr = '0; bmem_rdata = '0;
        check("err_set", {255'b0, err}, 256'd1);
        repeat (3) tick();
        check("err_sticky", {255'b0, err}, 256'd1);

        // reset in the middle of a write burst
        d_wdata = {64'hE3, 64'hE2, 64'hE1, 64'hE0};
        exp_bus(1'b1, 32'h0000_0500, 64'hE0);
        exp_bus(1'b1, 32'h0000_0500, 64'hE1);
        d_addr = 32'h0000_0500; d_write = 1'b1;
        tick();
        @(negedge clk);
        #1;
        rst = 1'b0;
        tick();
        check("midburst_reset_bus", {155'b0, bmem_addr, bmem_read, bmem_write, bmem_wdata, i_resp, d_resp, err}, '0);
        check("midburst_reset_i_rdata", i_rdata, '0);
        check("midburst_reset_d_rdata", d_rdata, '0);
        rst = 1'b1; d_write = 1'b0;
        repeat (2) tick();

        check("bus_q_drained", 256'(bus_q.size()), '0);
        check("resp_q_drained", 256'(resp_q.size()), '0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
